// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file: dump FSM states
// and default parameter values.
package regfile_mp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } dump_state_t;

  localparam int XLEN_DEF     = 32;
  localparam int NREGS_DEF    = 32;
  localparam int NRD_DEF      = 3;
  localparam int ZERO_REG_DEF = 1;
  localparam int BYPASS_DEF   = 1;

endpackage

// File: rtl/regfile_dump_ctrl.sv
// Dump sequencer: walks dump_idx over every register index with a
// valid/ready handshake, one beat per accepted transfer.
//
// state | meaning
// IDLE  | no dump in progress, dump_idx parked at 0
// RUN   | presenting beat dump_idx, advancing on dump_ready
module regfile_dump_ctrl
  import regfile_mp_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic          wrclk,
  input  logic          reset,
  input  logic          dump_start,
  input  logic          dump_ready,
  output logic          dump_valid,
  output logic          dump_last,
  output logic [AW-1:0] dump_idx,
  output logic          busy
);

  dump_state_t   state = IDLE;
  dump_state_t   state_next;
  logic [AW-1:0] idx = '0;
  logic          last_idx;
  logic          beat_done;

  assign last_idx  = (idx == AW'(NREGS - 1));
  assign beat_done = (state == RUN) && dump_ready;
  assign dump_idx  = idx;

  always_ff @(posedge wrclk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      if (state != RUN)
        idx <= '0;
      else if (beat_done)
        idx <= last_idx ? '0 : idx + AW'(1);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (dump_start) state_next = RUN;
      RUN:     if (beat_done && last_idx) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    dump_valid = 1'b0;
    dump_last  = 1'b0;
    busy       = 1'b0;
    case (state)
      RUN: begin
        dump_valid = 1'b1;
        dump_last  = last_idx;
        busy       = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/regfile_mp.sv
// Register file with NRD combinational read ports, two write ports
// (port 1 wins on collision), optional write bypass and a full dump port.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = NRD_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF,
  parameter int BYPASS   = BYPASS_DEF,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                wrclk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  input  logic                we0,
  input  logic [AW-1:0]       wa0,
  input  logic [XLEN-1:0]     wd0,
  input  logic                we1,
  input  logic [AW-1:0]       wa1,
  input  logic [XLEN-1:0]     wd1,
  input  logic                dump_start,
  output logic                dump_valid,
  input  logic                dump_ready,
  output logic [AW-1:0]       dump_idx,
  output logic [XLEN-1:0]     dump_data,
  output logic                dump_last,
  output logic                busy
);

  logic [XLEN-1:0] regs [NREGS] = '{default: '0};
  logic            we0_eff;
  logic            we1_eff;

  // Writes to the hardwired zero register and writes during reset never land,
  // so they must not be forwarded either.
  assign we0_eff = we0 && !reset && !((ZERO_REG != 0) && (wa0 == '0));
  assign we1_eff = we1 && !reset && !((ZERO_REG != 0) && (wa1 == '0));

  always_ff @(posedge wrclk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (we0_eff) regs[wa0] <= wd0;
      if (we1_eff) regs[wa1] <= wd1;  // later assignment gives port 1 priority
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] stored;
    logic [XLEN-1:0] value;

    assign addr   = rd_addr[k*AW +: AW];
    assign stored = ((ZERO_REG != 0) && (addr == '0)) ? '0 : regs[addr];

    always_comb begin
      value = stored;
      if (BYPASS != 0) begin
        if (we1_eff && (wa1 == addr))
          value = wd1;
        else if (we0_eff && (wa0 == addr))
          value = wd0;
      end
    end

    assign rd_data[k*XLEN +: XLEN] = value;
  end

  // Dump beats show the stored contents only; in-flight writes appear next cycle.
  assign dump_data = regs[dump_idx];

  regfile_dump_ctrl #(
    .NREGS(NREGS)
  ) u_dump_ctrl (
    .wrclk      (wrclk),
    .reset      (reset),
    .dump_start (dump_start),
    .dump_ready (dump_ready),
    .dump_valid (dump_valid),
    .dump_last  (dump_last),
    .dump_idx   (dump_idx),
    .busy       (busy)
  );

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL provide parameter XLEN, default 32, register data width.
REQ-002 SHALL provide parameter NREGS, default 32, register count (power of 2, >=2); AW = log2(NREGS).
REQ-003 SHALL provide parameter NRD, default 3, number of asynchronous read ports.
REQ-004 SHALL provide parameter ZERO_REG, default 1, 1 = register 0 hardwired to zero.
REQ-005 SHALL provide parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding.
REQ-006 SHALL have these ports:
- wrclk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- rd_addr  in  NRD*AW  packed read addresses; port k uses slice k.
- rd_data  out  NRD*XLEN  packed read data.
- we0, wa0, wd0  in  1, AW, XLEN  write port 0 enable, address, data.
- we1, wa1, wd1  in  1, AW, XLEN  write port 1 enable, address, data.
- dump_start  in  1  request a full register dump.
- dump_valid  out  1  dump beat valid.
- dump_ready  in  1  consumer accepts beat.
- dump_idx  out  AW  register index of current beat.
- dump_data  out  XLEN  register value of current beat.
- dump_last  out  1  current beat is index NREGS-1.
- busy  out  1  dump FSM not IDLE.

Function
REQ-007 Reads SHALL be combinational: rd_data[k] = regs[rd_addr[k]] with zero latency.
REQ-008 With ZERO_REG=1, reads of address 0 SHALL return 0 and writes to address 0 SHALL be discarded.
REQ-009 A write SHALL update regs[wa] on the rising wrclk edge where we=1; the new value SHALL be visible to reads in the cycle after that edge.
REQ-010 With BYPASS=1, a read whose address matches an active write (not discarded) in the same cycle SHALL return that write's data; with BYPASS=0 it SHALL return the stored value.
REQ-011 When we0 and we1 target the same address, port 1 SHALL win in both storage and bypass; different addresses SHALL both be written.
REQ-012 The dump FSM SHALL have states IDLE and RUN.
REQ-013 IDLE -> RUN SHALL occur on the edge where dump_start=1; dump_idx SHALL be 0 on entry.
REQ-014 In RUN, dump_valid SHALL be 1, dump_data SHALL equal stored regs[dump_idx] without bypass, and dump_last SHALL equal (dump_idx==NREGS-1).
REQ-015 A beat SHALL complete only when dump_valid and dump_ready are both 1; dump_idx SHALL then increment by 1; otherwise dump_idx and dump_data source SHALL hold.
REQ-016 Completion of the beat with dump_last=1 SHALL return the FSM to IDLE and reset dump_idx to 0.
REQ-017 dump_start SHALL be ignored while in RUN.
REQ-018 Writes SHALL continue during a dump; a beat SHALL show the stored value at the cycle it is presented.
REQ-019 In IDLE, dump_valid and dump_last SHALL be 0, and busy SHALL be 0.

Reset
REQ-020 On the edge where reset=1, all registers SHALL clear to 0, the FSM SHALL enter IDLE, and dump_idx SHALL be 0; simultaneous writes and dump_start SHALL be ignored.
REQ-021 Reset during RUN SHALL abort the dump, with dump_valid=0 from the next cycle.
REQ-022 Without a prior reset, register contents SHALL be initialised to 0 at simulation start.

Structure
REQ-023 A shared package SHALL hold the FSM state enumeration (IDLE, RUN) and default parameter constants.
REQ-024 The dump FSM SHALL be a sub-module named regfile_dump_ctrl that owns the state, dump_idx, and handshake; storage, write arbitration, and bypass SHALL stay in regfile_mp.

Verification
REQ-025 Write then read: we0=1, wa0=5, wd0=0xDEADBEEF; next cycle rd_addr[0]=5 -> 0xDEADBEEF; rd_addr[1]=0 -> 0.
REQ-026 Collision and bypass: we0 with wa0=7, wd0=0x11; we1 with wa1=7, wd1=0x22; rd_addr[2]=7 in the same cycle -> 0x22 (BYPASS=1); after the edge -> 0x22.
REQ-027 Zero register: we1=1, wa1=0, wd1=0xFFFFFFFF -> reads of address 0 return 0 in the same and next cycles.
REQ-028 Dump with backpressure: regs[i]=i*3; pulse dump_start; toggle dump_ready 1/0 -> 32 beats, idx 0..31, data i*3, dump_last only on idx 31, busy drops the cycle after the last beat completes.
REQ-029 Reset mid-dump: assert reset at idx 10 -> dump_valid=0 next cycle, all reads return 0, busy=0, and a later dump_start restarts at idx 0.
